// File: rtl/seq_detector_multi.sv
// seq_detector_multi: serial multi-pattern sequence detector.
//
// A single shared shift history is compared against NUM_PAT runtime-programmable
// patterns of up to MAX_LEN bits each. Every channel raises a registered
// one-cycle match pulse, and can run in overlapping or non-overlapping mode.
//
// Handshake: x_valid qualifies x on the rising edge of clk. There is no
// backpressure; every edge with x_valid high consumes exactly one bit, and
// edges with x_valid low leave all history and fill counts untouched.
//
// Optional build macro SEQ_DET_MATCH_CNT_EN adds per-channel saturating match
// counters on output match_cnt.
//
// Per-channel fill counts act as the channel state (FILL while below the
// effective length, ARMED once at or above it) and are exported flattened on
// dbg_fcnt, channel i at [i*LEN_W +: LEN_W].
module seq_detector_multi #(
  parameter int MAX_LEN = 8,
  parameter int NUM_PAT = 2,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       x,
  input  logic                       x_valid,
  input  logic                       clr,
  input  logic [NUM_PAT*MAX_LEN-1:0] pat,
  input  logic [NUM_PAT*LEN_W-1:0]   len,
  input  logic [NUM_PAT-1:0]         overlap,
  output logic [NUM_PAT-1:0]         y,
  output logic                       y_any,
  output logic [NUM_PAT*LEN_W-1:0]   dbg_fcnt
`ifdef SEQ_DET_MATCH_CNT_EN
  ,
  output logic [NUM_PAT*CNT_W-1:0]   match_cnt
`endif
);

  // Fill-count landmarks: empty after reset/clear/non-overlap match, full
  // once the whole history window holds valid bits.
  localparam logic [LEN_W-1:0] FCNT_EMPTY = '0;
  localparam logic [LEN_W-1:0] FCNT_FULL  = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d, hist_next;
  logic [LEN_W-1:0]   fcnt_q [NUM_PAT];
  logic [LEN_W-1:0]   fcnt_d [NUM_PAT];
  logic [NUM_PAT-1:0] m;
  logic [NUM_PAT-1:0] y_d;
  logic               y_any_d;

  // History as it will look after shifting in the current bit.
  always_comb begin
    hist_next = {hist_q[MAX_LEN-2:0], x};
  end

  // Per-channel match: window of eff_len newest bits equals the pattern and
  // enough valid bits have been seen since the last reset/clear/consume.
  always_comb begin
    int                 el;
    logic [MAX_LEN-1:0] mask;
    m = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      el = int'(len[i*LEN_W +: LEN_W]);
      if (el > MAX_LEN) el = MAX_LEN;
      mask = '0;
      for (int b = 0; b < MAX_LEN; b++) begin
        mask[b] = (b < el);
      end
      m[i] = x_valid && (el != 0) &&
             ((int'(fcnt_q[i]) + 1) >= el) &&
             ((hist_next & mask) == (pat[i*MAX_LEN +: MAX_LEN] & mask));
    end
  end

  // Next-state for history, fill counts and match outputs; clr wins over x_valid.
  always_comb begin
    hist_d  = hist_q;
    y_d     = '0;
    y_any_d = 1'b0;
    for (int i = 0; i < NUM_PAT; i++) begin
      fcnt_d[i] = fcnt_q[i];
    end
    if (clr) begin
      hist_d = '0;
      for (int i = 0; i < NUM_PAT; i++) begin
        fcnt_d[i] = FCNT_EMPTY;
      end
    end else if (x_valid) begin
      hist_d  = hist_next;
      y_d     = m;
      y_any_d = |m;
      for (int i = 0; i < NUM_PAT; i++) begin
        if (m[i] && !overlap[i]) begin
          fcnt_d[i] = FCNT_EMPTY;
        end else if (fcnt_q[i] != FCNT_FULL) begin
          fcnt_d[i] = fcnt_q[i] + LEN_W'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      y      <= '0;
      y_any  <= 1'b0;
      for (int i = 0; i < NUM_PAT; i++) begin
        fcnt_q[i] <= FCNT_EMPTY;
      end
    end else begin
      hist_q <= hist_d;
      y      <= y_d;
      y_any  <= y_any_d;
      for (int i = 0; i < NUM_PAT; i++) begin
        fcnt_q[i] <= fcnt_d[i];
      end
    end
  end

  // Export fill counts for observation.
  always_comb begin
    dbg_fcnt = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      dbg_fcnt[i*LEN_W +: LEN_W] = fcnt_q[i];
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_PAT];
  logic [CNT_W-1:0] cnt_d [NUM_PAT];

  // Saturating match counters, updated on the same edge as y.
  always_comb begin
    for (int i = 0; i < NUM_PAT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (m[i] && (~cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PAT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PAT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      match_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`else
  // Counter width is only meaningful when counters are built.
  logic [31:0] cnt_w_unused;
  assign cnt_w_unused = 32'(CNT_W);
`endif

endmodule

// File: doc/seq_detector_multi.md
Name: seq_detector_multi

Overview:
- Parametrised successor to the team's fixed two-pattern serial sequence detectors ("001"/"110" style).
- Watches a 1-bit serial stream qualified by a valid strobe and matches it against NUM_PAT runtime-programmable patterns, each up to MAX_LEN bits long.
- Raises a registered one-cycle match flag per pattern.
- Each pattern runs in overlapping or non-overlapping mode. Sits between a serial receiver and the control logic that reacts to framing or command sequences.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- NUM_PAT, 2, number of independent pattern channels (>=1).
- CNT_W, 8, width of each per-pattern match counter (optional feature only).
- LEN_W, $clog2(MAX_LEN+1), derived localparam, not overridable.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset; clears all state immediately on assertion, release synchronous to clk.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled on this edge only when high.
- clr  in  1  synchronous soft clear of history, fill counts, outputs and counters.
- pat  in  NUM_PAT*MAX_LEN  pattern i in pat[i*MAX_LEN +: MAX_LEN]; bit [len_i-1] is the first bit received, bit [0] the last.
- len  in  NUM_PAT*LEN_W  length of pattern i; 0 disables channel i.
- overlap  in  NUM_PAT  1 = overlapping matches allowed for channel i.
- y  out  NUM_PAT  registered match pulse per channel.
- y_any  out  1  registered OR of all match conditions, same cycle as y.

Behaviour:
- Reset (rst low): hist=0, all fcnt_i=0, y=0, y_any=0, counters=0. Takes effect asynchronously; no x_valid is accepted while rst is low.
- Shared history: hist[MAX_LEN-1:0], newest bit at [0]. On x_valid: hist <= {hist[MAX_LEN-2:0], x}. Without x_valid, hist holds.
- Per-channel fill count fcnt_i, range 0..MAX_LEN, acts as the channel state:
  - FILL: fcnt_i < eff_len_i.
  - ARMED: fcnt_i >= eff_len_i.
- eff_len_i = min(len_i, MAX_LEN). len_i=0: channel never matches; fcnt_i still counts.
- Match condition m_i, combinational on the current edge:
  - x_valid && eff_len_i != 0
  - && (fcnt_i+1) >= eff_len_i
  - && hist_next[eff_len_i-1:0] == pat_i[eff_len_i-1:0], where hist_next is the shifted value including x.
- Fill-count update on x_valid:
  - If m_i && !overlap[i]: fcnt_i <= 0 (bits of a matched window are not reused).
  - Otherwise: fcnt_i <= min(fcnt_i+1, MAX_LEN), saturating.
- Outputs: y[i] <= m_i and y_any <= |m. High for exactly one cycle after the edge that sampled the final pattern bit (Moore-style registered output, latency 1). Low on any cycle without x_valid.
- Overlap mode: back-to-back matches on consecutive valid bits are legal (e.g. pattern "11" on stream 1,1,1 gives two pulses).
- clr: synchronous; priority over x_valid. hist, fcnt, y, y_any and counters go to 0; the bit presented that cycle is discarded.
- pat/len/overlap: must be held stable while streaming. Any change requires clr to guarantee defined matching; without clr, the new config applies from the next edge using existing history.
- Gaps in x_valid do not break a sequence; only valid bits count.

Optional Feature:
- Macro SEQ_DET_MATCH_CNT_EN.
- When defined: adds output match_cnt [NUM_PAT*CNT_W]. Counter i increments on each m_i, saturates at 2^CNT_W-1, and is cleared by rst and clr. Readable in the same cycle y[i] is high (updated on the same edge).
- When undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- NUM_PAT=2, pat0=3'b001/len0=3, pat1=3'b110/len1=3, overlap=2'b11; stream 0,0,1,1,0 -> y[0] pulses after bit 3, y[1] after bit 5; y_any pulses in both cycles; no other pulses.
- pat0=4'b0101, len0=4; stream 0,1,0,1,0,1,0,1 -> with overlap=1, y[0] after bits 4, 6, 8; with overlap=0, only after bits 4 and 8.
- Same setup as the first scenario with x_valid deasserted for 3 cycles between bits 2 and 3 -> y[0] still pulses after bit 3; y stays 0 during the gap.
- rst pulled low asynchronously mid-edge-window after bits 0,0 -> y=0 immediately; bit 1 alone after release gives no match; 0,0,1 afterwards matches.
- clr and x_valid high together on the final bit of 0,0,1 -> no pulse; the next 0,0,1 matches after its third bit. With len0=0 the channel never pulses.
- With SEQ_DET_MATCH_CNT_EN, CNT_W=2, pattern "1" len=1, overlap=1, stream of 6 ones -> match_cnt0 = 1,2,3,3,3,3; clr returns it to 0.
